ps2_game_cmd: RTL and testbench

//  Consumes PS/2 scan-code bytes from PS2_Keyboard_Driver (data/ready/rdn) and turns them into Tetris

---
 rtl/ps2_game_cmd_pkg.sv | 69 ++++++
 rtl/ps2_game_cmd_key_repeat.sv | 38 +++
 rtl/ps2_game_cmd.sv | 159 +++++++++++++++
 tb/tb_ps2_game_cmd.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_game_cmd_pkg.sv
// Shared PS/2 scan-code defines plus parser types and key-mapping helper for the Tetris command decoder.
// The `define block is the keyboard scan-code header reused by any other keyboard consumer.
`ifndef PS2_KEYCODES_VH
`define PS2_KEYCODES_VH
`define PS2_PREFIX_EXT   8'hE0
`define PS2_PREFIX_BRK   8'hF0
`define PS2_PREFIX_PAUSE 8'hE1
`define PS2_RESP_ACK     8'hFA
`define PS2_RESP_BAT_OK  8'hAA
`define PS2_RESP_RESEND  8'hFE
`define PS2_KEY_LEFT     8'h6B
`define PS2_KEY_RIGHT    8'h74
`define PS2_KEY_DOWN     8'h72
`define PS2_KEY_UP       8'h75
`define PS2_KEY_SPACE    8'h29
`define PS2_KEY_P        8'h4D
`define PS2_KEY_ENTER    8'h5A
`endif

package ps2_game_cmd_pkg;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } parse_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LEFT,
    OWN_RIGHT
  } lr_owner_t;

  localparam logic [7:0] CODE_EXT = `PS2_PREFIX_EXT;
  localparam logic [7:0] CODE_BRK = `PS2_PREFIX_BRK;

  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_ROTATE = 3;
  localparam int KEY_DROP   = 4;
  localparam int KEY_PAUSE  = 5;
  localparam int KEY_START  = 6;

  // Arrows only count with the E0 prefix; keypad codes without it fall through as unmapped.
  function automatic logic [6:0] keyMap(input logic [7:0] code, input logic ext);
    logic [6:0] m;
    m = '0;
    if (ext) begin
      case (code)
        `PS2_KEY_LEFT:  m[KEY_LEFT]   = 1'b1;
        `PS2_KEY_RIGHT: m[KEY_RIGHT]  = 1'b1;
        `PS2_KEY_DOWN:  m[KEY_DOWN]   = 1'b1;
        `PS2_KEY_UP:    m[KEY_ROTATE] = 1'b1;
        default:        m = '0;
      endcase
    end else begin
      case (code)
        `PS2_KEY_SPACE: m[KEY_DROP]  = 1'b1;
        `PS2_KEY_P:     m[KEY_PAUSE] = 1'b1;
        `PS2_KEY_ENTER: m[KEY_START] = 1'b1;
        default:        m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_game_cmd_key_repeat.sv
// Auto-repeat timer for one key: first repeat DELAY_CYC after the press, then every RATE_CYC while held.
module key_repeat #(
  parameter int DELAY_CYC = 25_000_000,
  parameter int RATE_CYC  = 5_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_press,
  input  logic i_hold,
  output logic o_rep_pulse
);

  localparam int CW = $clog2(DELAY_CYC + 1);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(DELAY_CYC);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(RATE_CYC);

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  // Gating with the live hold suppresses any pulse in the release cycle itself.
  assign w_expire    = i_hold && (r_cnt == CW'(1));
  assign o_rep_pulse = w_expire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_press) begin
      r_cnt <= DELAY_LOAD;
    end else if (!i_hold) begin
      r_cnt <= '0;
    end else if (w_expire) begin
      r_cnt <= RATE_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ps2_game_cmd.sv
// PS/2 scan-code to Tetris command decoder: read handshake, E0/F0 prefix parser, held-key tracking
// and auto-repeat for left/right/down with last-pressed-wins ownership between left and right.
module ps2_game_cmd #(
  parameter int DELAY_CYC = 25_000_000,
  parameter int RATE_CYC  = 5_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_kb_data,
  input  logic       i_kb_ready,
  output logic       o_kb_rdn,
  output logic       o_cmd_left,
  output logic       o_cmd_right,
  output logic       o_cmd_down,
  output logic       o_cmd_rotate,
  output logic       o_cmd_drop,
  output logic       o_cmd_pause,
  output logic       o_cmd_start,
  output logic [6:0] o_held
);

  import ps2_game_cmd_pkg::*;

  logic         r_rdPend;
  logic         r_blank;
  logic [7:0]   r_byte;
  parse_state_t r_state, w_stateNext;
  lr_owner_t    r_owner, w_ownerNext;
  logic [6:0]   r_held, w_heldNext;
  logic [6:0]   w_key, w_press, w_rel;
  logic         w_isMake, w_isBrk;
  logic         w_accept;
  logic         w_repLeft, w_repRight, w_repDown;
  logic         w_holdLeft, w_holdRight;

  // A byte is taken at most once per three cycles: latch, strobe, then one blind cycle.
  assign w_accept = i_kb_ready && !r_rdPend && !r_blank;
  assign o_kb_rdn = ~r_rdPend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdPend <= 1'b0;
      r_blank  <= 1'b0;
      r_byte   <= '0;
    end else begin
      r_rdPend <= w_accept;
      r_blank  <= r_rdPend;
      if (w_accept) r_byte <= i_kb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= PS_IDLE;
      r_held  <= '0;
      r_owner <= OWN_NONE;
    end else begin
      r_state <= w_stateNext;
      r_held  <= w_heldNext;
      r_owner <= w_ownerNext;
    end
  end

  // The latched byte is decoded during its strobe cycle so command pulses line up with kb_rdn low.
  always_comb begin
    w_stateNext = r_state;
    w_key       = '0;
    w_isMake    = 1'b0;
    w_isBrk     = 1'b0;
    if (r_rdPend) begin
      case (r_state)
        PS_IDLE: begin
          if (r_byte == CODE_EXT) begin
            w_stateNext = PS_EXT;
          end else if (r_byte == CODE_BRK) begin
            w_stateNext = PS_BRK;
          end else begin
            w_key    = keyMap(r_byte, 1'b0);
            w_isMake = 1'b1;
          end
        end
        PS_EXT: begin
          if (r_byte == CODE_BRK) begin
            w_stateNext = PS_EXT_BRK;
          end else begin
            w_key       = keyMap(r_byte, 1'b1);
            w_isMake    = 1'b1;
            w_stateNext = PS_IDLE;
          end
        end
        PS_BRK: begin
          w_key       = keyMap(r_byte, 1'b0);
          w_isBrk     = 1'b1;
          w_stateNext = PS_IDLE;
        end
        PS_EXT_BRK: begin
          w_key       = keyMap(r_byte, 1'b1);
          w_isBrk     = 1'b1;
          w_stateNext = PS_IDLE;
        end
        default: w_stateNext = PS_IDLE;
      endcase
    end
  end

  // Typematic makes on an already-held key produce no press; breaks of unheld keys are no-ops.
  assign w_press    = w_isMake ? (w_key & ~r_held) : '0;
  assign w_rel      = w_isBrk  ? (w_key &  r_held) : '0;
  assign w_heldNext = (r_held | w_press) & ~w_rel;

  always_comb begin
    w_ownerNext = r_owner;
    if (w_press[KEY_LEFT]) begin
      w_ownerNext = OWN_LEFT;
    end else if (w_press[KEY_RIGHT]) begin
      w_ownerNext = OWN_RIGHT;
    end else if ((r_owner == OWN_LEFT && w_rel[KEY_LEFT]) ||
                 (r_owner == OWN_RIGHT && w_rel[KEY_RIGHT])) begin
      w_ownerNext = OWN_NONE;
    end
  end

  assign w_holdLeft  = w_heldNext[KEY_LEFT]  && (w_ownerNext == OWN_LEFT);
  assign w_holdRight = w_heldNext[KEY_RIGHT] && (w_ownerNext == OWN_RIGHT);

  key_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_repLeft (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_press    (w_press[KEY_LEFT]),
    .i_hold     (w_holdLeft),
    .o_rep_pulse(w_repLeft)
  );

  key_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_repRight (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_press    (w_press[KEY_RIGHT]),
    .i_hold     (w_holdRight),
    .o_rep_pulse(w_repRight)
  );

  key_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_repDown (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_press    (w_press[KEY_DOWN]),
    .i_hold     (w_heldNext[KEY_DOWN]),
    .o_rep_pulse(w_repDown)
  );

  assign o_cmd_left   = w_press[KEY_LEFT]  | w_repLeft;
  assign o_cmd_right  = w_press[KEY_RIGHT] | w_repRight;
  assign o_cmd_down   = w_press[KEY_DOWN]  | w_repDown;
  assign o_cmd_rotate = w_press[KEY_ROTATE];
  assign o_cmd_drop   = w_press[KEY_DROP];
  assign o_cmd_pause  = w_press[KEY_PAUSE];
  assign o_cmd_start  = w_press[KEY_START];
  assign o_held       = r_held;

endmodule

// File: tb/tb_ps2_game_cmd.sv
// Directed self-checking bench for ps2_game_cmd with a small keyboard-driver model (DELAY=20, RATE=5).
module tb_ps2_game_cmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kbData = 8'h00;
  logic       kbReady = 1'b0;
  logic       kbRdn;
  logic       cmdLeft, cmdRight, cmdDown, cmdRotate, cmdDrop, cmdPause, cmdStart;
  logic [6:0] held;

  int cycle = 0;
  int checkCount = 0;
  int passCount = 0;
  int leftTimes[$];
  int rightTimes[$];
  int downTimes[$];
  int rotateCnt = 0, dropCnt = 0, pauseCnt = 0, startCnt = 0;
  int rdnCnt = 0, anyCmd = 0;

  always #5 clk = ~clk;

  ps2_game_cmd #(.DELAY_CYC(20), .RATE_CYC(5)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_kb_data   (kbData),
    .i_kb_ready  (kbReady),
    .o_kb_rdn    (kbRdn),
    .o_cmd_left  (cmdLeft),
    .o_cmd_right (cmdRight),
    .o_cmd_down  (cmdDown),
    .o_cmd_rotate(cmdRotate),
    .o_cmd_drop  (cmdDrop),
    .o_cmd_pause (cmdPause),
    .o_cmd_start (cmdStart),
    .o_held      (held)
  );

  // Sample all outputs mid-cycle and log when each pulse was seen.
  always @(negedge clk) begin
    cycle++;
    if (!kbRdn) rdnCnt++;
    if (cmdLeft) leftTimes.push_back(cycle);
    if (cmdRight) rightTimes.push_back(cycle);
    if (cmdDown) downTimes.push_back(cycle);
    if (cmdRotate) rotateCnt++;
    if (cmdDrop) dropCnt++;
    if (cmdPause) pauseCnt++;
    if (cmdStart) startCnt++;
    if (cmdLeft | cmdRight | cmdDown | cmdRotate | cmdDrop | cmdPause | cmdStart) anyCmd++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Driver model: present a byte, wait for the read strobe, drop ready on the popping edge.
  task automatic applyStimulus(input logic [7:0] b, output int rdnAt);
    bit got;
    got = 1'b0;
    rdnAt = -1;
    @(posedge clk); #2;
    kbData = b;
    kbReady = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      if (!kbRdn) begin
        got = 1'b1;
        rdnAt = cycle;
      end
    end
    if (!got) checkOutput("rdnTimeout", 0, 1);
    @(posedge clk); #2;
    kbReady = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse times: the press, then press+20, then every 5 cycles strictly before release.
  task automatic checkCadence(input string tag, input int q[$], input int p, input int r);
    int expT[$];
    expT.push_back(p);
    for (int t = p + 20; t < r; t += 5) expT.push_back(t);
    checkOutput({tag, "Count"}, q.size(), expT.size());
    for (int i = 0; i < expT.size() && i < q.size(); i++)
      checkOutput({tag, "Time"}, q[i], expT[i]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r1, pL, pR, rL, rR, pD, rD, t, snap, rdnSnap;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rstRdn", int'(kbRdn), 1);
    checkOutput("rstHeld", int'(held), 0);
    checkOutput("rstCmd", int'({cmdLeft, cmdRight, cmdDown, cmdRotate, cmdDrop, cmdPause, cmdStart}), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    waitCycles(3);
    rdnSnap = rdnCnt;

    // 1: extended left make
    applyStimulus(8'hE0, r1);
    applyStimulus(8'h6B, pL);
    checkOutput("t1RdnCount", rdnCnt - rdnSnap, 2);
    checkOutput("t1LeftCount", leftTimes.size(), 1);
    checkOutput("t1LeftAt", leftTimes.size() > 0 ? leftTimes[0] : -1, pL);
    checkOutput("t1Held", int'(held), 1);

    // 2: hold left, then release
    waitCycles(60);
    applyStimulus(8'hE0, t);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h6B, rL);
    waitCycles(30);
    checkCadence("t2Left", leftTimes, pL, rL);
    checkOutput("t2Held", int'(held), 0);

    // 3: typematic repeats of left are ignored
    leftTimes.delete();
    applyStimulus(8'hE0, t);
    applyStimulus(8'h6B, pL);
    repeat (4) begin
      applyStimulus(8'hE0, t);
      applyStimulus(8'h6B, t);
    end
    waitCycles(15);
    applyStimulus(8'hE0, t);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h6B, rL);
    waitCycles(30);
    checkCadence("t3Left", leftTimes, pL, rL);
    checkOutput("t3Held", int'(held), 0);

    // 4: drop / pause / start, single pulses only
    applyStimulus(8'h29, t);
    checkOutput("t4DropMake", dropCnt, 1);
    checkOutput("t4HeldDrop", int'(held), 7'b0010000);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h29, t);
    applyStimulus(8'h4D, t);
    applyStimulus(8'h5A, t);
    waitCycles(40);
    checkOutput("t4Drop", dropCnt, 1);
    checkOutput("t4Pause", pauseCnt, 1);
    checkOutput("t4Start", startCnt, 1);
    checkOutput("t4Held", int'(held), 7'b1100000);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h4D, t);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h5A, t);
    checkOutput("t4HeldClr", int'(held), 0);
    checkOutput("t4PauseAfterBrk", pauseCnt, 1);

    // down repeats on its own timer; up arrow gives a single rotate pulse
    applyStimulus(8'hE0, t);
    applyStimulus(8'h72, pD);
    waitCycles(30);
    applyStimulus(8'hE0, t);
    applyStimulus(8'h75, t);
    applyStimulus(8'hE0, t);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h72, rD);
    waitCycles(10);
    checkCadence("tDown", downTimes, pD, rD);
    checkOutput("tRotate", rotateCnt, 1);
    checkOutput("tDownHeld", int'(held), 7'b0001000);
    applyStimulus(8'hE0, t);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h75, t);

    // 5: right pressed while left held takes over the repeat
    leftTimes.delete();
    rightTimes.delete();
    applyStimulus(8'hE0, t);
    applyStimulus(8'h6B, pL);
    waitCycles(30);
    applyStimulus(8'hE0, t);
    applyStimulus(8'h74, pR);
    waitCycles(50);
    applyStimulus(8'hE0, t);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h74, rR);
    waitCycles(40);
    checkCadence("t5Left", leftTimes, pL, pR);
    checkCadence("t5Right", rightTimes, pR, rR);
    checkOutput("t5Held", int'(held), 1);
    applyStimulus(8'hE0, t);
    applyStimulus(8'hF0, t);
    applyStimulus(8'h6B, t);
    checkOutput("t5HeldClr", int'(held), 0);

    // 6: reset after E0 discards the prefix; ACK/BAT bytes do nothing
    snap = anyCmd;
    rdnSnap = rdnCnt;
    applyStimulus(8'hE0, t);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    applyStimulus(8'h6B, t);
    waitCycles(30);
    checkOutput("t6NoCmd", anyCmd - snap, 0);
    checkOutput("t6Held", int'(held), 0);
    applyStimulus(8'hFA, t);
    applyStimulus(8'hAA, t);
    waitCycles(10);
    checkOutput("t6AckNoCmd", anyCmd - snap, 0);
    checkOutput("t6AckHeld", int'(held), 0);
    checkOutput("t6RdnCount", rdnCnt - rdnSnap, 4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
